// File: rtl/sum_nibble_reader_pkg.sv
// rtl/sum_nibble_reader_pkg.sv - shared state encoding and build defaults for the nibble reader
package sum_nibble_reader_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHOW_LO = 2'd1,
        SHOW_HI = 2'd2
    } state_t;

    localparam int DB_CYCLES_DEFAULT = 4;
    localparam int CW_DEFAULT        = 20;

endpackage

// File: rtl/sum_nibble_reader_if.sv
// rtl/sum_nibble_reader_if.sv - adder, button and LED signal bundle for the nibble reader
interface sum_nibble_reader_if;

    logic [6:0] z;
    logic       carry;
    logic       pb_capture;
    logic       pb_next;
    logic [3:0] led;
    logic       hi_sel;
    logic       valid;

    modport master (
        output z, carry, pb_capture, pb_next,
        input  led, hi_sel, valid
    );

    modport slave (
        input  z, carry, pb_capture, pb_next,
        output led, hi_sel, valid
    );

endinterface

// File: rtl/sum_nibble_reader_pb_debounce.sv
// rtl/sum_nibble_reader_pb_debounce.sv - pushbutton synchronizer, debouncer and press-pulse generator
module pb_debounce #(
    parameter int DB_CYCLES = 4,
    parameter int CW        = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pb_raw,
    output logic pb_level,
    output logic pb_pulse
);

    logic          sync_0;
    logic          sync_1;
    logic          deb;
    logic          deb_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_0 <= 1'b0;
            sync_1 <= 1'b0;
            deb    <= 1'b0;
            deb_q  <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_0 <= pb_raw;
            sync_1 <= sync_0;
            deb_q  <= deb;
            // Any edge that agrees with the debounced level restarts the stability count
            if (sync_1 == deb) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                deb <= sync_1;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign pb_level = deb;
    assign pb_pulse = deb & ~deb_q;

endmodule

// File: rtl/sum_nibble_reader.sv
// rtl/sum_nibble_reader.sv - snapshots the adder result and steps it out a nibble at a time on LEDs
module sum_nibble_reader
    import sum_nibble_reader_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int CW        = CW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sum_nibble_reader_if.slave   bus
);

    logic       cap_pulse;
    logic       nxt_pulse;
    state_t     state, state_n;
    logic [7:0] snap, snap_n;
    logic [3:0] led_r, led_n;
    logic       hi_r, hi_n;
    logic       valid_r, valid_n;

    pb_debounce #(.DB_CYCLES(DB_CYCLES), .CW(CW)) u_db_capture (
        .clk      (clk),
        .rst_n    (rst_n),
        .pb_raw   (bus.pb_capture),
        .pb_level (),
        .pb_pulse (cap_pulse)
    );

    pb_debounce #(.DB_CYCLES(DB_CYCLES), .CW(CW)) u_db_next (
        .clk      (clk),
        .rst_n    (rst_n),
        .pb_raw   (bus.pb_next),
        .pb_level (),
        .pb_pulse (nxt_pulse)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            snap    <= 8'h00;
            led_r   <= 4'h0;
            hi_r    <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            state   <= state_n;
            snap    <= snap_n;
            led_r   <= led_n;
            hi_r    <= hi_n;
            valid_r <= valid_n;
        end
    end

    // Outputs are decoded from the next state so they land in flops on the same edge as the state
    always_comb begin
        state_n = state;
        snap_n  = snap;
        led_n   = 4'h0;
        hi_n    = 1'b0;
        valid_n = 1'b0;

        if (cap_pulse) begin
            snap_n  = {bus.carry, bus.z};
            state_n = SHOW_LO;
        end else if (nxt_pulse) begin
            case (state)
                SHOW_LO: state_n = SHOW_HI;
                SHOW_HI: state_n = SHOW_LO;
                default: state_n = state;
            endcase
        end

        case (state_n)
            SHOW_LO: begin
                led_n   = snap_n[3:0];
                valid_n = 1'b1;
            end
            SHOW_HI: begin
                led_n   = snap_n[7:4];
                hi_n    = 1'b1;
                valid_n = 1'b1;
            end
            default: begin
                led_n   = 4'h0;
            end
        endcase
    end

    assign bus.led    = led_r;
    assign bus.hi_sel = hi_r;
    assign bus.valid  = valid_r;

endmodule

// File: tb/tb_sum_nibble_reader.sv
// tb/tb_sum_nibble_reader.sv - scoreboard bench for the nibble reader
module tb_sum_nibble_reader;
    import sum_nibble_reader_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sum_nibble_reader_if bus ();

    sum_nibble_reader #(.DB_CYCLES(4), .CW(20)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [5:0] exp_q[$];
    logic [5:0] prev_out = 6'h00;
    logic [5:0] cur_out;
    bit         mon_en = 1'b0;
    int         n_checks = 0;
    int         n_pass = 0;
    state_t     m_st = IDLE;
    logic [7:0] m_snap = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [5:0] out_of(input state_t st, input logic [7:0] s);
        case (st)
            SHOW_LO: return {s[3:0], 1'b0, 1'b1};
            SHOW_HI: return {s[7:4], 1'b1, 1'b1};
            default: return 6'h00;
        endcase
    endfunction

    task automatic model_capture();
        m_snap = {bus.carry, bus.z};
        m_st   = SHOW_LO;
        exp_q.push_back(out_of(m_st, m_snap));
    endtask

    task automatic model_next();
        if (m_st != IDLE) begin
            m_st = (m_st == SHOW_LO) ? SHOW_HI : SHOW_LO;
            exp_q.push_back(out_of(m_st, m_snap));
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            cur_out = {bus.led, bus.hi_sel, bus.valid};
            if (cur_out !== prev_out) begin
                if (exp_q.size() == 0) check("unexpected_change", cur_out, prev_out);
                else check("scoreboard", cur_out, exp_q.pop_front());
                prev_out = cur_out;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic cap, input logic nxt, input int hold);
        tick(1);
        bus.pb_capture = cap;
        bus.pb_next    = nxt;
        tick(hold);
        bus.pb_capture = 1'b0;
        bus.pb_next    = 1'b0;
        tick(12);
    endtask

    task automatic do_reset();
        tick(1);
        #2;
        rst_n = 1'b0;
        if (m_st != IDLE) exp_q.push_back(6'h00);
        m_st   = IDLE;
        m_snap = 8'h00;
        #1;
        check("rst_led", bus.led, 0);
        check("rst_hi_sel", bus.hi_sel, 0);
        check("rst_valid", bus.valid, 0);
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        bus.z = 7'h00;
        bus.carry = 1'b0;
        bus.pb_capture = 1'b0;
        bus.pb_next = 1'b0;
        rst_n = 1'b0;
        #1;
        check("init_led", bus.led, 0);
        check("init_valid", bus.valid, 0);
        tick(3);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // 1: capture latency, then next steps and wraps
        bus.z = 7'h5A;
        bus.carry = 1'b1;
        tick(1);
        bus.pb_capture = 1'b1;
        model_capture();
        n = 0;
        while (n < 20 && bus.valid !== 1'b1) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("cap_latency_edges", n, 7);
        check("t1_led_lo", bus.led, 4'hA);
        tick(3);
        bus.pb_capture = 1'b0;
        tick(12);
        model_next();
        press(1'b0, 1'b1, 6);
        check("t1_led_hi", bus.led, 4'hD);
        check("t1_hi_sel", bus.hi_sel, 1);
        model_next();
        press(1'b0, 1'b1, 6);
        check("t1_wrap_led", bus.led, 4'hA);
        check("t1_q_empty", exp_q.size(), 0);

        // 2: next in IDLE is ignored, then capture shows z[3:0]
        do_reset();
        bus.z = 7'h26;
        bus.carry = 1'b0;
        model_next();
        press(1'b0, 1'b1, 8);
        check("t2_idle_state", dut.state, IDLE);
        check("t2_idle_valid", bus.valid, 0);
        model_capture();
        press(1'b1, 1'b0, 8);
        check("t2_led", bus.led, 4'h6);

        // 3: short bounce rejected, bounce then stable high captures once
        do_reset();
        tick(1);
        for (int i = 0; i < 4; i++) begin
            bus.pb_capture = ~i[0];
            tick(1);
        end
        tick(10);
        check("t3_bounce_valid", bus.valid, 0);
        for (int i = 0; i < 4; i++) begin
            bus.pb_capture = ~i[0];
            tick(1);
        end
        bus.pb_capture = 1'b1;
        model_capture();
        tick(8);
        bus.pb_capture = 1'b0;
        tick(12);
        check("t3_one_capture_q", exp_q.size(), 0);
        check("t3_valid", bus.valid, 1);

        // 4: snapshot holds while adder outputs move
        bus.z = 7'h13;
        bus.carry = 1'b0;
        model_capture();
        press(1'b1, 1'b0, 8);
        bus.z = 7'h7F;
        bus.carry = 1'b1;
        tick(10);
        check("t4_led_stable", bus.led, 4'h3);
        model_next();
        press(1'b0, 1'b1, 8);
        check("t4_led_hi", bus.led, 4'h1);

        // 5: simultaneous press in SHOW_HI - capture wins, no repeat while held
        bus.z = 7'h2C;
        bus.carry = 1'b1;
        model_capture();
        press(1'b1, 1'b1, 20);
        check("t5_led", bus.led, 4'hC);
        check("t5_hi_sel", bus.hi_sel, 0);
        check("t5_state", dut.state, SHOW_LO);

        // 6: async reset mid-SHOW_HI, release with next held stays IDLE
        model_next();
        press(1'b0, 1'b1, 8);
        check("t6_pre_led", bus.led, 4'hA);
        bus.pb_next = 1'b1;
        do_reset();
        tick(20);
        check("t6_state", dut.state, IDLE);
        check("t6_valid", bus.valid, 0);
        bus.pb_next = 1'b0;
        tick(12);
        check("final_q_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
